// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command-driven sequencer for a 4-bit counter with programmable prescaler
module counter_seq_ctrl #(
   parameter int unsigned PRESCALE_W = 24,
   parameter logic [3:0]  LIMIT_RST  = 4'd15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [3:0]            cmd_data,
   input  logic [PRESCALE_W-1:0] div_value,
   output logic [3:0]            count,
   output logic                  tick,
   output logic                  wrap,
   output logic                  done,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_NOP0      = 3'b000;
   localparam logic [2:0] OP_START     = 3'b001;
   localparam logic [2:0] OP_STOP      = 3'b010;
   localparam logic [2:0] OP_CLEAR     = 3'b011;
   localparam logic [2:0] OP_LOAD      = 3'b100;
   localparam logic [2:0] OP_SET_LIMIT = 3'b101;
   localparam logic [2:0] OP_SET_MODE  = 3'b110;
   localparam logic [2:0] OP_NOP7      = 3'b111;

   localparam logic [PRESCALE_W-1:0] PRESC_ZERO = '0;
   localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   // Architectural state
   state_e                  state_q, state_d;
   logic [3:0]              count_q, count_d;
   logic [3:0]              limit_q, limit_d;
   logic                    dir_q, dir_d;          // 0 up, 1 down
   logic                    oneshot_q, oneshot_d;
   logic [PRESCALE_W-1:0]   div_q, div_d;
   logic [PRESCALE_W-1:0]   presc_q, presc_d;

   // Registered outputs
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    tick_q, tick_d;
   logic                    wrap_q, wrap_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   // Decoded conditions
   logic                    accept;
   logic                    expire;
   logic                    terminal;
   logic [3:0]              step_count;
   logic [PRESCALE_W-1:0]   div_sel;

   assign cmd_ready = cmd_ready_q;
   assign count     = count_q;
   assign tick      = tick_q;
   assign wrap      = wrap_q;
   assign done      = done_q;
   assign busy      = busy_q;

   // Handshake and prescaler expiry decode; a zero divisor is treated as 1
   always_comb begin
      accept  = cmd_valid & cmd_ready_q;
      expire  = (state_q == ST_RUN) && (presc_q == (div_q - PRESC_ONE));
      div_sel = (div_value == PRESC_ZERO) ? PRESC_ONE : div_value;
   end

   // Candidate next count for a tick; terminal flags the wrap/done boundary
   always_comb begin
      terminal   = dir_q ? (count_q == 4'd0) : (count_q == limit_q);
      step_count = count_q;
      if (dir_q) begin
         step_count = terminal ? limit_q : (count_q - 4'd1);
      end else begin
         // Above-limit values roll 15->0 naturally without a wrap event
         step_count = terminal ? 4'd0 : (count_q + 4'd1);
      end
   end

   // Next-state logic: an accepted command takes priority over a tick
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      limit_d     = limit_q;
      dir_d       = dir_q;
      oneshot_d   = oneshot_q;
      div_d       = div_q;
      presc_d     = PRESC_ZERO;
      tick_d      = 1'b0;
      wrap_d      = 1'b0;
      done_d      = 1'b0;
      cmd_ready_d = ~accept;

      if (state_q == ST_RUN) begin
         presc_d = expire ? PRESC_ZERO : (presc_q + PRESC_ONE);
      end

      if (accept) begin
         unique case (cmd_op)
            OP_START: begin
               state_d = ST_RUN;
               div_d   = div_sel;
               presc_d = PRESC_ZERO;
            end
            OP_STOP: begin
               if (state_q == ST_RUN) begin
                  state_d = ST_IDLE;
                  presc_d = PRESC_ZERO;
               end
            end
            OP_CLEAR: begin
               count_d = 4'd0;
               presc_d = PRESC_ZERO;
               if (state_q == ST_DONE) begin
                  state_d = ST_IDLE;
               end
            end
            OP_LOAD: begin
               count_d = cmd_data;
               presc_d = PRESC_ZERO;
               if (state_q == ST_DONE) begin
                  state_d = ST_IDLE;
               end
            end
            OP_SET_LIMIT: begin
               limit_d = cmd_data;
            end
            OP_SET_MODE: begin
               // Mode changes mid-run would corrupt the terminal test; ignore them
               if (state_q != ST_RUN) begin
                  dir_d     = cmd_data[0];
                  oneshot_d = cmd_data[1];
               end
            end
            OP_NOP0, OP_NOP7: begin
               state_d = state_q;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else if (expire) begin
         tick_d = 1'b1;
         if (terminal && oneshot_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end else begin
            count_d = step_count;
            wrap_d  = terminal;
         end
      end

      busy_d = (state_d == ST_RUN);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter, limit, mode and prescaler registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= 4'd0;
         limit_q   <= LIMIT_RST;
         dir_q     <= 1'b0;
         oneshot_q <= 1'b0;
         div_q     <= PRESC_ONE;
         presc_q   <= PRESC_ZERO;
      end else begin
         count_q   <= count_d;
         limit_q   <= limit_d;
         dir_q     <= dir_d;
         oneshot_q <= oneshot_d;
         div_q     <= div_d;
         presc_q   <= presc_d;
      end
   end

   // Output pulse and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready_q <= 1'b1;
         tick_q      <= 1'b0;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         tick_q      <= tick_d;
         wrap_q      <= wrap_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

   localparam int PW = 24;

   localparam logic [2:0] OP_START     = 3'b001;
   localparam logic [2:0] OP_STOP      = 3'b010;
   localparam logic [2:0] OP_CLEAR     = 3'b011;
   localparam logic [2:0] OP_LOAD      = 3'b100;
   localparam logic [2:0] OP_SET_LIMIT = 3'b101;
   localparam logic [2:0] OP_SET_MODE  = 3'b110;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [3:0]    cmd_data;
   logic [PW-1:0] div_value;
   logic [3:0]    count;
   logic          tick;
   logic          wrap;
   logic          done;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   counter_seq_ctrl #(
      .PRESCALE_W (PW),
      .LIMIT_RST  (4'd15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .div_value (div_value),
      .count     (count),
      .tick      (tick),
      .wrap      (wrap),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Present one command, waiting (bounded) for cmd_ready; returns 1 ns after the accepting edge
   task automatic send(input logic [2:0] op, input logic [3:0] data, input logic [PW-1:0] div);
      int waited;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 20) begin
         cycle();
         waited++;
      end
      check("send_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      div_value = div;
      cycle();
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
   endtask

   initial begin
      logic [3:0] exp_cnt;
      logic [3:0] down_seq [4];
      logic       down_wrap [4];

      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_data  = 4'd0;
      div_value = '0;

      // Reset values
      cycle();
      cycle();
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_tick",  {31'd0, tick},  32'd0);
      check("rst_wrap",  {31'd0, wrap},  32'd0);
      check("rst_done",  {31'd0, done},  32'd0);
      reset = 1'b1;
      cycle();

      // 1: up, continuous, limit 15, divide by 3
      send(OP_SET_LIMIT, 4'd15, '0);
      send(OP_START, 4'd0, 24'd3);
      check("t1_busy", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= 16; i++) begin
         cycle();
         check("t1_gap_tick", {31'd0, tick}, 32'd0);
         cycle();
         check("t1_gap_tick", {31'd0, tick}, 32'd0);
         check("t1_gap_wrap", {31'd0, wrap}, 32'd0);
         cycle();
         exp_cnt = 4'(i);
         check("t1_tick",  {31'd0, tick}, 32'd1);
         check("t1_count", {28'd0, count}, {28'd0, exp_cnt});
         check("t1_wrap",  {31'd0, wrap}, (i == 16) ? 32'd1 : 32'd0);
      end
      send(OP_STOP, 4'd0, '0);
      check("t1_stop_busy", {31'd0, busy}, 32'd0);

      // 2: up, one-shot, limit 5, divide by 1
      send(OP_SET_MODE, 4'b0010, '0);
      send(OP_SET_LIMIT, 4'd5, '0);
      send(OP_CLEAR, 4'd0, '0);
      check("t2_clear", {28'd0, count}, 32'd0);
      send(OP_START, 4'd0, 24'd1);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         check("t2_count", {28'd0, count}, i);
         check("t2_tick",  {31'd0, tick}, 32'd1);
         check("t2_nodone", {31'd0, done}, 32'd0);
      end
      cycle();
      check("t2_done",      {31'd0, done},  32'd1);
      check("t2_busy",      {31'd0, busy},  32'd0);
      check("t2_hold",      {28'd0, count}, 32'd5);
      check("t2_nowrap",    {31'd0, wrap},  32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t2_done_off", {31'd0, done},  32'd0);
         check("t2_no_tick",  {31'd0, tick},  32'd0);
         check("t2_hold2",    {28'd0, count}, 32'd5);
      end

      // 3: down, continuous, limit 9, load 2, divide by 2
      send(OP_SET_MODE, 4'b0001, '0);
      send(OP_SET_LIMIT, 4'd9, '0);
      send(OP_LOAD, 4'd2, '0);
      check("t3_load", {28'd0, count}, 32'd2);
      check("t3_idle", {31'd0, busy},  32'd0);
      send(OP_START, 4'd0, 24'd2);
      down_seq  = '{4'd1, 4'd0, 4'd9, 4'd8};
      down_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_gap_tick", {31'd0, tick}, 32'd0);
         cycle();
         check("t3_count", {28'd0, count}, {28'd0, down_seq[i]});
         check("t3_tick",  {31'd0, tick}, 32'd1);
         check("t3_wrap",  {31'd0, wrap}, {31'd0, down_wrap[i]});
      end

      // 4: divide by 4, STOP accepted on the expiry edge
      send(OP_START, 4'd0, 24'd4);
      check("t4_start_hold", {28'd0, count}, 32'd8);
      cycle();
      cycle();
      cycle();
      check("t4_pre_tick", {31'd0, tick}, 32'd0);
      cycle();
      check("t4_count", {28'd0, count}, 32'd7);
      check("t4_tick",  {31'd0, tick},  32'd1);
      cycle();
      cycle();
      cycle();
      send(OP_STOP, 4'd0, '0);
      check("t4_stop_count", {28'd0, count}, 32'd7);
      check("t4_stop_tick",  {31'd0, tick},  32'd0);
      check("t4_stop_busy",  {31'd0, busy},  32'd0);
      cycle();
      cycle();
      check("t4_idle_count", {28'd0, count}, 32'd7);
      send(OP_START, 4'd0, 24'd1);
      cycle();
      check("t4_resume", {28'd0, count}, 32'd6);
      send(OP_STOP, 4'd0, '0);
      check("t4_stop2_count", {28'd0, count}, 32'd6);
      check("t4_stop2_busy",  {31'd0, busy},  32'd0);

      // 5: held cmd_valid, LOAD 7 then SET_LIMIT 3
      cycle();
      check("t5_ready0", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = 4'd7;
      cycle();
      check("t5_ready1", {31'd0, cmd_ready}, 32'd0);
      check("t5_load",   {28'd0, count},     32'd7);
      cmd_op   = OP_SET_LIMIT;
      cmd_data = 4'd3;
      cycle();
      check("t5_ready2", {31'd0, cmd_ready}, 32'd1);
      cycle();
      check("t5_ready3", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      send(OP_SET_MODE, 4'b0000, '0);
      send(OP_LOAD, 4'd1, '0);
      send(OP_START, 4'd0, 24'd1);
      cycle();
      check("t5_c2", {28'd0, count}, 32'd2);
      cycle();
      check("t5_c3", {28'd0, count}, 32'd3);
      cycle();
      check("t5_lim_wrap",  {31'd0, wrap},  32'd1);
      check("t5_lim_count", {28'd0, count}, 32'd0);
      send(OP_SET_MODE, 4'b0001, '0);
      check("t5_mode_supp", {28'd0, count}, 32'd0);
      check("t5_mode_tick", {31'd0, tick},  32'd0);
      cycle();
      check("t5_still_up", {28'd0, count}, 32'd1);
      cycle();
      check("t5_still_up2", {28'd0, count}, 32'd2);

      // 6: asynchronous reset mid-run at count 6
      send(OP_STOP, 4'd0, '0);
      send(OP_SET_LIMIT, 4'd15, '0);
      send(OP_LOAD, 4'd5, '0);
      send(OP_START, 4'd0, 24'd4);
      cycle();
      cycle();
      cycle();
      cycle();
      check("t6_count6", {28'd0, count}, 32'd6);
      check("t6_busy",   {31'd0, busy},  32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_count", {28'd0, count},     32'd0);
      check("t6_rst_busy",  {31'd0, busy},      32'd0);
      check("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("t6_idle_busy",  {31'd0, busy},  32'd0);
         check("t6_idle_count", {28'd0, count}, 32'd0);
         check("t6_idle_tick",  {31'd0, tick},  32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
